// File: rtl/ctrl_bubble_pipe_if.sv
// Handshake bundle between the decoder/hazard unit (master) and the control pipeline (slave).
interface ctrl_bubble_pipe_if #(
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned STAGES = 3,
  parameter int unsigned LEN_W  = 3
);
  logic [CTRL_W-1:0]        ctrl_in;
  logic                     bubble_req;
  logic [LEN_W-1:0]         bubble_len;
  logic                     flush;
  logic [STAGES*CTRL_W-1:0] ctrl_out;
  logic                     stall_out;
  logic                     busy;

  modport master (
    output ctrl_in, bubble_req, bubble_len, flush,
    input  ctrl_out, stall_out, busy
  );

  modport slave (
    input  ctrl_in, bubble_req, bubble_len, flush,
    output ctrl_out, stall_out, busy
  );
endinterface

// File: rtl/ctrl_bubble_pipe.sv
// Control-bundle pipeline with multi-cycle bubble injection and young-stage flush.
// Define BUBBLE_CNT_EN to add the saturating bubble_cnt output.
module ctrl_bubble_pipe #(
  parameter int unsigned       CTRL_W      = 10,
  parameter int unsigned       STAGES      = 3,
  parameter int unsigned       LEN_W       = 3,
  parameter int unsigned       FLUSH_DEPTH = 1,
  parameter logic [CTRL_W-1:0] BUBBLE_VAL  = '0
`ifdef BUBBLE_CNT_EN
  ,
  parameter int unsigned       CNT_W       = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  ctrl_bubble_pipe_if.slave bus
`ifdef BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  typedef enum logic {StIdle, StBubble} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [CTRL_W-1:0] stages_q [STAGES];
  logic [CTRL_W-1:0] stages_d [STAGES];
  logic              accept;
  logic              inject;

  assign accept = (state_q == StIdle) && bus.bubble_req && (bus.bubble_len != '0) && !bus.flush;
  // A bubble enters stage 0 exactly on the cycles the front end is held.
  assign inject = !bus.flush && (accept || (state_q == StBubble));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (bus.flush) begin
      state_d     = StIdle;
      remaining_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            remaining_d = bus.bubble_len - LEN_W'(1);
            state_d     = (bus.bubble_len > LEN_W'(1)) ? StBubble : StIdle;
          end
        end
        StBubble: begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    stages_d[0] = inject ? BUBBLE_VAL : bus.ctrl_in;
    for (int unsigned k = 1; k < STAGES; k++) stages_d[k] = stages_q[k-1];
    if (bus.flush) begin
      for (int unsigned k = 0; k < FLUSH_DEPTH; k++) stages_d[k] = BUBBLE_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) stages_q[k] <= BUBBLE_VAL;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      for (int unsigned k = 0; k < STAGES; k++) stages_q[k] <= stages_d[k];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_out
    assign bus.ctrl_out[g*CTRL_W +: CTRL_W] = stages_q[g];
  end

  assign bus.stall_out = inject;
  assign bus.busy      = (state_q == StBubble);

`ifdef BUBBLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts FSM-injected bubbles only; flush clears are excluded since inject is low then.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inject && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bubble_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_bubble_pipe.sv
// Randomised scoreboard bench for ctrl_bubble_pipe against a cycle-level bubble/flush model.
module tb_ctrl_bubble_pipe;
  localparam int unsigned CW    = 10;
  localparam int unsigned ST    = 3;
  localparam int unsigned LW    = 3;
  localparam int unsigned FD    = 2;
  localparam int unsigned CNTW  = 4;
  localparam int unsigned CMAX  = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_bubble_pipe_if #(.CTRL_W(CW), .STAGES(ST), .LEN_W(LW)) bus ();

`ifdef BUBBLE_CNT_EN
  logic [CNTW-1:0] bubble_cnt;
  ctrl_bubble_pipe #(.CTRL_W(CW), .STAGES(ST), .LEN_W(LW), .FLUSH_DEPTH(FD),
                     .BUBBLE_VAL('0), .CNT_W(CNTW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .bubble_cnt(bubble_cnt));
`else
  ctrl_bubble_pipe #(.CTRL_W(CW), .STAGES(ST), .LEN_W(LW), .FLUSH_DEPTH(FD),
                     .BUBBLE_VAL('0)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  typedef struct {
    logic [ST*CW-1:0] ctrl;
    bit               stall;
    bit               busy;
    int unsigned      cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: stage contents and number of stall cycles still owed by the current burst.
  logic [CW-1:0] m_st [ST];
  int unsigned   m_left;
  int unsigned   m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ctrl_out", 64'(bus.ctrl_out), 64'(e.ctrl));
      check("stall_out", 64'(bus.stall_out), 64'(e.stall));
      check("busy", 64'(bus.busy), 64'(e.busy));
`ifdef BUBBLE_CNT_EN
      check("bubble_cnt", 64'(bubble_cnt), 64'(e.cnt));
`endif
    end
  end

  task automatic model_reset();
    for (int k = 0; k < ST; k++) m_st[k] = '0;
    m_left = 0;
    m_cnt  = 0;
  endtask

  // One clock cycle: apply inputs, queue expected outputs, then advance the model past the edge.
  task automatic step(input logic [CW-1:0] c, input bit req, input logic [LW-1:0] len,
                      input bit fl, input bit rst, input bit chk);
    exp_t e;
    bit   take;
    @(posedge clk);
    #1;
    reset          = rst;
    bus.ctrl_in    = c;
    bus.bubble_req = req;
    bus.bubble_len = len;
    bus.flush      = fl;
    take = !fl && (m_left == 0) && req && (len != 0);
    for (int k = 0; k < ST; k++) e.ctrl[k*CW +: CW] = m_st[k];
    e.stall = !fl && (take || m_left > 0);
    e.busy  = (m_left > 0);
    e.cnt   = m_cnt;
    if (chk) exp_q.push_back(e);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = ST - 1; k > 0; k--) m_st[k] = m_st[k-1];
      if (fl) begin
        m_left = 0;
        for (int k = 0; k < FD; k++) m_st[k] = '0;
      end else if (m_left > 0 || take) begin
        m_st[0] = '0;
        m_left  = take ? int'(len) - 1 : m_left - 1;
        if (m_cnt < CMAX) m_cnt++;
      end else begin
        m_st[0] = c;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.ctrl_in = '0; bus.bubble_req = 1'b0; bus.bubble_len = '0; bus.flush = 1'b0;
    model_reset();
    step(10'h3FF, 0, 0, 0, 1, 0);
    step(10'h3FF, 0, 0, 0, 1, 1);
    // Pass-through
    step(10'h0A1, 0, 0, 0, 0, 1);
    step(10'h0B2, 0, 0, 0, 0, 1);
    step(10'h0C3, 1, 0, 0, 0, 1);
    step(10'h0D4, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(10'h155, 0, 0, 0, 0, 1);
    // Load-use burst of 2
    step(10'h111, 1, 2, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(10'h122 + 10'(i), 0, 0, 0, 0, 1);
    // Burst of 5 with a len-7 request held through it
    step(10'h201, 1, 5, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(10'h210 + 10'(i), 1, 7, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(10'h230 + 10'(i), 0, 0, 0, 0, 1);
    // Flush on the second cycle of a len-4 burst
    step(10'h301, 0, 0, 0, 0, 1);
    step(10'h302, 1, 4, 0, 0, 1);
    step(10'h303, 1, 4, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(10'h310 + 10'(i), 0, 0, 0, 0, 1);
    // Flush together with a request in IDLE drops the request
    step(10'h321, 1, 3, 1, 0, 1);
    step(10'h322, 0, 0, 0, 0, 1);
    // Twenty single-cycle bubbles drive the counter into saturation
    for (int i = 0; i < 20; i++) step(10'h040 + 10'(i), 1, 1, 0, 0, 1);
    for (int i = 0; i < 2; i++) step(10'h060, 0, 0, 0, 0, 1);
    // Random traffic, with one mid-run reset
    for (int i = 0; i < 1500; i++) begin
      step(10'($urandom), ($urandom_range(9) < 4), 3'($urandom), ($urandom_range(11) == 0),
           (i == 700), 1);
    end
    step(10'h000, 0, 0, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
